// File: rtl/vsr_pkg.sv
// Shared types and constants for the vector stream reader.
package vsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vsr_state_e;

  localparam int VSR_BUF_DEPTH = 2;
  localparam int VSR_CNT_W     = $clog2(VSR_BUF_DEPTH + 1);

endpackage

// File: rtl/vsr_skid_fifo.sv
// Two-entry output buffer: push/pop in the same cycle, head is the oldest entry.
module vsr_skid_fifo
  import vsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [VSR_CNT_W-1:0] count,
  output logic [WIDTH-1:0]     head
);

  logic [WIDTH-1:0]     mem_q [VSR_BUF_DEPTH];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [VSR_CNT_W-1:0] count_q;
  logic                 do_push;
  logic                 do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != VSR_CNT_W'(VSR_BUF_DEPTH)) || do_pop);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VSR_BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + VSR_CNT_W'(1);
        2'b01:   count_q <= count_q - VSR_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vector_stream_reader.sv
// Reads `length` consecutive (wrapping) addresses from NUM_CH parallel memories and
// streams one multi-channel beat per element. Optional abort input: define VSR_ABORT_EN.
module vector_stream_reader
  import vsr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
`ifdef VSR_ABORT_EN
  input  logic                         abort,
`endif
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          length,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int OW = NUM_CH * DATA_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;
  localparam int OCC_W = VSR_CNT_W + 1;

  vsr_state_e           state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]        reads_left_q;
  logic [LW-1:0]        beats_left_q;
  logic                 inflight_q;
  logic                 busy_q;
  logic                 done_q;
  logic [VSR_CNT_W-1:0] fifo_count;
  logic [OW-1:0]        fifo_head;
  logic                 pop;
  logic                 abort_act;
  logic [OCC_W-1:0]     occ;

`ifdef VSR_ABORT_EN
  assign abort_act = abort && busy_q;
`else
  assign abort_act = 1'b0;
`endif

  // Output handshake: a beat transfers on a cycle where out_valid && out_ready; once
  // out_valid rises, out_data/out_last hold until that cycle (head only moves on pop).
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_head;
  assign out_last  = out_valid && (beats_left_q == LW'(1)) && !abort_act;
  assign pop       = out_valid && out_ready;

  // Buffer slots already spoken for after this cycle; a read is issued only into a free slot.
  assign occ   = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);
  assign rd_en = (state_q == RUN) && !abort_act && (occ < OCC_W'(VSR_BUF_DEPTH));

  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  vsr_skid_fifo #(
    .WIDTH(OW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort_act),
    .push     (inflight_q),
    .push_data(rd_data),
    .pop      (pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      reads_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_en;
      if (pop) beats_left_q <= beats_left_q - LW'(1);
      if (abort_act) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (length == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q      <= RUN;
                busy_q       <= 1'b1;
                addr_q       <= base_addr;
                reads_left_q <= length;
                beats_left_q <= length;
              end
            end
          end
          RUN: begin
            if (rd_en) begin
              addr_q       <= addr_q + ADDR_WIDTH'(1);
              reads_left_q <= reads_left_q - LW'(1);
              if (reads_left_q == LW'(1)) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (pop && (beats_left_q == LW'(1))) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_stream_reader.sv
// Bench for vector_stream_reader: memory model, scoreboard of expected beats, vector table.
module tb_vector_stream_reader;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int AW = 5;
  localparam int OW = NC * DW;
  localparam int W  = OW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort_tb;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, rd_en, out_valid, out_ready, out_last;
  logic [AW-1:0] rd_addr;
  logic [OW-1:0] rd_data, out_data;

  vector_stream_reader #(.DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef VSR_ABORT_EN
    .abort    (abort_tb),
`endif
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: data valid one cycle after rd_en, garbage otherwise
  logic [OW-1:0] mem [DEPTH];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : OW'($urandom);

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_addr;
  int reads_exp, issued, accepted;
  int first_valid_cyc, first_rd_cyc, last_hs_cyc, done_cyc, done_count;
  bit busy_seen;
  bit stall_prev = 1'b0;
  logic [W-1:0] stall_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: samples on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] got;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_en) begin
        chk("rd_issue_expected", 64'(reads_exp != 0), 64'd1);
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
        exp_addr = exp_addr + 1'b1;
        if (reads_exp != 0) reads_exp--;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        issued++;
      end
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'({out_last, out_data}), 64'(stall_word));
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_expected", 64'd0, 64'd1);
        end else begin
          got = exp_q.pop_front();
          chk("beat", 64'({out_last, out_data}), 64'(got));
        end
        accepted++;
        last_hs_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready && !abort_tb;
      stall_word = {out_last, out_data};
      if (busy) begin
        busy_seen = 1'b1;
        chk("occupancy_le2", 64'((issued - accepted) <= 2), 64'd1);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        chk("busy_low_with_done", 64'(busy), 64'd0);
      end
    end
  end

  // driver tasks
  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic start_transfer(input int base, input int len, input int mode, output int t0);
    logic [W-1:0] w;
    @(posedge clk); #1;
    first_valid_cyc = -1; first_rd_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    done_count = 0; busy_seen = 1'b0; issued = 0; accepted = 0;
    exp_addr = AW'(base); reads_exp = len;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1) ? 1'b1 : 1'b0, mem[(base + i) % DEPTH]};
      exp_q.push_back(w);
    end
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len);
    out_ready = ready_for(mode, 0);
    t0 = cyc;
  endtask

  task automatic wait_done(input int mode, input bit poke);
    int k = 1;
    int after = 0;
    while (after < 3 && k < 500) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = ready_for(mode, k);
      if (poke && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        length = (AW+1)'($urandom_range(1, DEPTH));
      end
      if (done_count > 0) after++;
      k++;
    end
    start = 1'b0;
    chk("transfer_finished", 64'(after), 64'd3);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (accepted < n && k < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    chk("reached_beat", 64'(accepted >= n), 64'd1);
  endtask

  typedef struct {
    int base;
    int len;
    int mode;
    bit poke;
    int exp_beats;
    int exp_first_rd;
    int exp_latency;
  } vec_t;

  task automatic check_result(input vec_t v, input int t0);
    chk("beats", 64'(accepted), 64'(v.exp_beats));
    chk("reads_issued", 64'(issued), 64'(v.exp_beats));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_count), 64'd1);
    if (v.len == 0) begin
      chk("zero_len_done_delay", 64'(done_cyc - t0), 64'd1);
      chk("zero_len_busy", 64'(busy_seen), 64'd0);
    end else begin
      chk("done_after_last", 64'(done_cyc - last_hs_cyc), 64'd1);
    end
    if (v.exp_latency >= 0) begin
      chk("first_rd_delay", 64'(first_rd_cyc - t0), 64'(v.exp_first_rd));
      chk("first_valid_delay", 64'(first_valid_cyc - t0), 64'(v.exp_latency));
      chk("back_to_back", 64'(last_hs_cyc - first_valid_cyc), 64'(v.len - 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int t0;
    vec_t fresh;
    vecs[0] = '{base: 0,  len: 32, mode: 0, poke: 0, exp_beats: 32, exp_first_rd: 1,  exp_latency: 3};
    vecs[1] = '{base: 30, len: 4,  mode: 0, poke: 0, exp_beats: 4,  exp_first_rd: 1,  exp_latency: 3};
    vecs[2] = '{base: 5,  len: 8,  mode: 1, poke: 0, exp_beats: 8,  exp_first_rd: -1, exp_latency: -1};
    vecs[3] = '{base: 0,  len: 0,  mode: 0, poke: 0, exp_beats: 0,  exp_first_rd: -1, exp_latency: -1};
    vecs[4] = '{base: 17, len: 1,  mode: 0, poke: 0, exp_beats: 1,  exp_first_rd: 1,  exp_latency: 3};
    vecs[5] = '{base: 9,  len: 20, mode: 2, poke: 1, exp_beats: 20, exp_first_rd: -1, exp_latency: -1};
    for (int i = 0; i < DEPTH; i++) mem[i] = OW'($urandom);

    rst_n = 1'b0; start = 1'b0; abort_tb = 1'b0; out_ready = 1'b0;
    base_addr = '0; length = '0; reads_exp = 0; exp_addr = '0;
    issued = 0; accepted = 0; done_count = 0;
    first_valid_cyc = -1; first_rd_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      start_transfer(vecs[v].base, vecs[v].len, vecs[v].mode, t0);
      wait_done(vecs[v].mode, vecs[v].poke);
      check_result(vecs[v], t0);
    end

    // reset in the middle of an 8-beat transfer
    start_transfer(3, 8, 0, t0);
    wait_beats(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    exp_q.delete(); reads_exp = 0; done_count = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("no_done_after_reset", 64'(done_count), 64'd0);
    fresh = '{base: 0, len: 5, mode: 0, poke: 0, exp_beats: 5, exp_first_rd: 1, exp_latency: 3};
    start_transfer(fresh.base, fresh.len, fresh.mode, t0);
    wait_done(fresh.mode, fresh.poke);
    check_result(fresh, t0);

`ifdef VSR_ABORT_EN
    start_transfer(0, 16, 0, t0);
    wait_beats(2);
    chk("abort_busy_before", 64'(busy), 64'd1);
    abort_tb = 1'b1;
    @(posedge clk); #1;
    abort_tb = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    exp_q.delete(); reads_exp = 0;
    @(posedge clk); #1;
    chk("abort_done_pulse", 64'(done), 64'd0);
    chk("abort_idle_valid", 64'(out_valid), 64'd0);
    start_transfer(fresh.base, fresh.len, fresh.mode, t0);
    wait_done(fresh.mode, fresh.poke);
    check_result(fresh, t0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
